// File: rtl/spi_flash_sched.sv
// Shares one SPI flash read engine between an instruction-fetch port (0) and a data-load port (1).
// Requests are held until flash init completes, arbitrated round-robin, and guarded by a timeout.
module spi_flash_sched #(
  parameter int unsigned ADDR_W    = 24,
  parameter int unsigned DATA_SIZE = 32,
  parameter bit          QUAD_EN   = 1'b1,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic                 init_done,
  input  logic                 req0_valid,
  input  logic [ADDR_W-1:0]    req0_addr,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [ADDR_W-1:0]    req1_addr,
  output logic                 req1_ready,
  output logic                 rsp0_valid,
  output logic                 rsp1_valid,
  output logic [DATA_SIZE-1:0] rsp_data,
  output logic                 rsp_err,
  output logic                 eng_cmd_valid,
  input  logic                 eng_cmd_ready,
  output logic [7:0]           eng_cmd_op,
  output logic [ADDR_W-1:0]    eng_cmd_addr,
  input  logic                 eng_rsp_valid,
  input  logic [DATA_SIZE-1:0] eng_rsp_data,
  output logic                 eng_abort,
  output logic                 busy
);

  localparam int unsigned CntW = 8;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StWaitInit, StIdle, StIssue, StWaitRsp, StResp} state_e;

  state_e                 state_q, state_d;
  logic                   last_grant_q, last_grant_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_SIZE-1:0]   rsp_data_q, rsp_data_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   grant_pick;

  // On a tie the port that did not win last time is chosen; last_grant also names the active port.
  assign grant_pick = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    rsp_data_d    = rsp_data_q;
    rsp_err_d     = rsp_err_q;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    rsp0_valid    = 1'b0;
    rsp1_valid    = 1'b0;
    eng_cmd_valid = 1'b0;
    eng_abort     = 1'b0;
    unique case (state_q)
      StWaitInit: begin
        if (init_done) state_d = StIdle;
      end
      StIdle: begin
        if (!init_done) begin
          state_d = StWaitInit;
        end else if (req0_valid || req1_valid) begin
          last_grant_d = grant_pick;
          addr_d       = grant_pick ? req1_addr : req0_addr;
          req0_ready   = ~grant_pick;
          req1_ready   = grant_pick;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        eng_cmd_valid = 1'b1;
        cnt_d         = '0;
        if (eng_cmd_ready) state_d = StWaitRsp;
      end
      StWaitRsp: begin
        cnt_d = cnt_q + 1'b1;
        // A response in the timeout cycle still wins over the abort.
        if (eng_rsp_valid) begin
          rsp_data_d = eng_rsp_data;
          rsp_err_d  = 1'b0;
          state_d    = StResp;
        end else if (cnt_q == CntLast) begin
          eng_abort  = 1'b1;
          rsp_data_d = '1;
          rsp_err_d  = 1'b1;
          state_d    = StResp;
        end
      end
      StResp: begin
        rsp0_valid = ~last_grant_q;
        rsp1_valid = last_grant_q;
        cnt_d      = '0;
        state_d    = StIdle;
      end
      default: state_d = StWaitInit;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q      <= StWaitInit;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      addr_q       <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign eng_cmd_op   = QUAD_EN ? 8'hEB : 8'h03;
  assign eng_cmd_addr = addr_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;
  assign busy         = (state_q != StIdle) && (state_q != StWaitInit);

endmodule

// File: tb/tb_spi_flash_sched.sv
// Randomized bench for spi_flash_sched against a transaction-level arbitration/timeout model.
module tb_spi_flash_sched;

  localparam int unsigned AW = 24;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic          init_done;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_addr, req1_addr;
  logic          req0_ready, req1_ready;
  logic          rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          eng_cmd_valid, eng_cmd_ready;
  logic [7:0]    eng_cmd_op;
  logic [AW-1:0] eng_cmd_addr;
  logic          eng_rsp_valid;
  logic [DW-1:0] eng_rsp_data;
  logic          eng_abort, busy;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: which port won last, and the response word currently held.
  int            exp_last;
  logic [DW-1:0] exp_data;
  logic          exp_err;

  spi_flash_sched #(
    .ADDR_W(AW), .DATA_SIZE(DW), .QUAD_EN(1'b1), .TIMEOUT(TO)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .init_done(init_done),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .eng_cmd_valid(eng_cmd_valid), .eng_cmd_ready(eng_cmd_ready), .eng_cmd_op(eng_cmd_op),
    .eng_cmd_addr(eng_cmd_addr), .eng_rsp_valid(eng_rsp_valid), .eng_rsp_data(eng_rsp_data),
    .eng_abort(eng_abort), .busy(busy)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, 64'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err,
                              eng_cmd_valid, eng_abort, busy}), 64'd0);
    check({tag, "_data"}, 64'(rsp_data), 64'd0);
    check({tag, "_addr"}, 64'(eng_cmd_addr), 64'd0);
  endtask

  // One full transaction starting in an IDLE cycle. rsp_dly counts WAIT_RSP cycles before the
  // engine answers; rsp_dly >= TO means the engine stays silent and answers late instead.
  task automatic run_txn(input bit r0, input bit r1, input logic [AW-1:0] a0,
                         input logic [AW-1:0] a1, input int ready_dly, input int rsp_dly,
                         input logic [DW-1:0] data, input bit drop_init);
    int            g;
    int            k;
    bit            done;
    logic [AW-1:0] ga;
    @(negedge ACLK);
    req0_valid = r0; req0_addr = a0; req1_valid = r1; req1_addr = a1;
    eng_rsp_valid = 1'b0;
    #1;
    check("idle_rsp0", 64'(rsp0_valid), 64'd0);
    check("idle_rsp1", 64'(rsp1_valid), 64'd0);
    check("held_data", 64'(rsp_data), 64'(exp_data));
    check("held_err", 64'(rsp_err), 64'(exp_err));
    check("idle_busy", 64'(busy), 64'd0);
    g  = (r0 && r1) ? 1 - exp_last : (r1 ? 1 : 0);
    exp_last = g;
    ga = (g == 1) ? a1 : a0;
    check("grant_ready0", 64'(req0_ready), 64'(g == 0));
    check("grant_ready1", 64'(req1_ready), 64'(g == 1));

    for (int i = 0; i <= ready_dly; i++) begin
      @(negedge ACLK);
      if (i == 0) begin
        if (g == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
      end
      eng_cmd_ready = (i == ready_dly);
      eng_rsp_valid = 1'($urandom_range(0, 1));
      eng_rsp_data  = $urandom;
      #1;
      check("cmd_valid", 64'(eng_cmd_valid), 64'd1);
      check("cmd_op", 64'(eng_cmd_op), 64'h0EB);
      check("cmd_addr", 64'(eng_cmd_addr), 64'(ga));
      check("issue_ready", 64'({req0_ready, req1_ready}), 64'd0);
      check("issue_busy", 64'(busy), 64'd1);
    end

    k = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge ACLK);
      eng_cmd_ready = 1'b0;
      if (drop_init && k == 0) init_done = 1'b0;
      eng_rsp_valid = (k == rsp_dly);
      eng_rsp_data  = (k == rsp_dly) ? data : $urandom;
      #1;
      check("abort", 64'(eng_abort), 64'((k == int'(TO) - 1) && (k != rsp_dly)));
      check("wait_cmd_valid", 64'(eng_cmd_valid), 64'd0);
      check("wait_rsp", 64'({rsp0_valid, rsp1_valid}), 64'd0);
      if (k == rsp_dly || k == int'(TO) - 1) done = 1'b1;
      k++;
    end
    if (rsp_dly < int'(TO)) begin
      exp_data = data;
      exp_err  = 1'b0;
    end else begin
      exp_data = '1;
      exp_err  = 1'b1;
    end

    @(negedge ACLK);
    // A silent engine answers late, during RESP; it must be ignored.
    eng_rsp_valid = (rsp_dly >= int'(TO));
    eng_rsp_data  = $urandom;
    #1;
    check("rsp0_valid", 64'(rsp0_valid), 64'(g == 0));
    check("rsp1_valid", 64'(rsp1_valid), 64'(g == 1));
    check("rsp_data", 64'(rsp_data), 64'(exp_data));
    check("rsp_err", 64'(rsp_err), 64'(exp_err));
    check("resp_abort", 64'(eng_abort), 64'd0);
  endtask

  // After init_done dropped mid-transaction: one IDLE cycle, then WAIT_INIT, then re-enable.
  task automatic reinit();
    @(negedge ACLK);
    eng_rsp_valid = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b0;
    #1;
    check("noinit_idle_ready", 64'(req0_ready), 64'd0);
    @(negedge ACLK);
    #1;
    check("noinit_wait_ready", 64'(req0_ready), 64'd0);
    check("noinit_busy", 64'(busy), 64'd0);
    init_done = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ARESETn = 1'b0; init_done = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_addr = '0; req1_addr = '0;
    eng_cmd_ready = 1'b0; eng_rsp_valid = 1'b0; eng_rsp_data = '0;
    exp_last = 1; exp_data = '0; exp_err = 1'b0;

    repeat (2) @(negedge ACLK);
    #1;
    check_reset_outputs("reset");

    @(negedge ACLK);
    ARESETn = 1'b1; req0_valid = 1'b1; req0_addr = 24'h000100;
    for (int i = 0; i < 20; i++) begin
      @(negedge ACLK);
      #1;
      check("preinit_ready0", 64'(req0_ready), 64'd0);
      check("preinit_cmd", 64'(eng_cmd_valid), 64'd0);
    end
    @(negedge ACLK);
    init_done = 1'b1;
    #1;
    check("init_edge_ready0", 64'(req0_ready), 64'd0);

    run_txn(1'b1, 1'b0, 24'h000100, 24'h0, 0, 5, 32'hDEADBEEF, 1'b0);
    run_txn(1'b0, 1'b1, 24'h0, 24'h0ABCDE, 1, 40, 32'h12345678, 1'b0);
    run_txn(1'b1, 1'b1, 24'h111111, 24'h222222, 0, int'(TO) - 1, 32'hCAFEF00D, 1'b0);
    run_txn(1'b1, 1'b0, 24'h333333, 24'h0, 2, 0, 32'h0BADC0DE, 1'b1);
    reinit();
    run_txn(1'b1, 1'b0, 24'h444444, 24'h0, 0, 1, 32'h55AA55AA, 1'b0);

    // Asynchronous reset while waiting for the engine.
    @(negedge ACLK);
    req0_valid = 1'b1; req0_addr = 24'h777777; req1_valid = 1'b0;
    @(negedge ACLK);
    req0_valid = 1'b0; eng_cmd_ready = 1'b1;
    @(negedge ACLK);
    eng_cmd_ready = 1'b0;
    #2;
    ARESETn = 1'b0;
    #1;
    check_reset_outputs("midop_reset");
    exp_last = 1; exp_data = '0; exp_err = 1'b0;
    @(negedge ACLK);
    ARESETn = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("post_reset_ready", 64'({req0_ready, req1_ready}), 64'd0);

    // Contention from reset: model must yield grants 0,1,0,1.
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b1, 1'b1, AW'($urandom), AW'($urandom), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 4)), $urandom, 1'b0);
      check("contention_grant", 64'(exp_last), 64'(i % 2));
    end

    for (int i = 0; i < 40; i++) begin
      bit r0;
      bit r1;
      r0 = 1'($urandom_range(0, 1));
      r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
      run_txn(r0, r1, AW'($urandom), AW'($urandom), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 11)), $urandom, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_flash_sched.md
# spi_flash_sched

Scheduler that shares one SPI flash read engine between two requesters: port 0 (instruction fetch) and port 1 (data load). It holds every request until the flash init sequence reports completion. It arbitrates round-robin, issues one read command at a time to the engine, and returns the 32-bit word with a timeout guard. It sits between the core's memory-side request ports and the SPI read engine, beside the flash init block whose `flag_end_init` drives `init_done`.

## Interface
Parameters:
- ADDR_W, 24, flash byte-address width
- DATA_SIZE, 32, response word width
- QUAD_EN, 1, 1 selects opcode 8'hEB (quad fast read), 0 selects 8'h03 (standard read)
- TIMEOUT, 64, max cycles in WAIT_RSP before error; legal range 2..255

Ports:
- ACLK  in  1  clock, all logic on the rising edge
- ARESETn  in  1  asynchronous active-low reset
- init_done  in  1  level; flash init complete
- req0_valid / req1_valid  in  1  request pending
- req0_addr / req1_addr  in  ADDR_W  read address, stable while valid
- req0_ready / req1_ready  out  1  accept strobe, combinational, one cycle
- rsp0_valid / rsp1_valid  out  1  response strobe, one cycle
- rsp_data  out  DATA_SIZE  response word, shared, held until the next response
- rsp_err  out  1  response is a timeout error, held with rsp_data
- eng_cmd_valid  out  1  command to engine
- eng_cmd_ready  in  1  engine accepts command
- eng_cmd_op  out  8  opcode
- eng_cmd_addr  out  ADDR_W  latched address
- eng_rsp_valid  in  1  engine data strobe
- eng_rsp_data  in  DATA_SIZE  engine data
- eng_abort  out  1  one-cycle pulse on timeout
- busy  out  1  state is not IDLE and not WAIT_INIT

## Operation
- States:
  - WAIT_INIT: no grants. Goes to IDLE when init_done=1.
  - IDLE: if init_done=0, go to WAIT_INIT. Else, if any request is pending, grant one, raise its reqN_ready, latch its address and the grant id, and go to ISSUE.
  - ISSUE: eng_cmd_valid=1 until eng_cmd_ready=1, then go to WAIT_RSP.
  - WAIT_RSP: cycle counter runs. On eng_rsp_valid=1, latch data, set err=0, go to RESP. If the counter reaches TIMEOUT-1 with no response, pulse eng_abort, set rsp_data=all ones and err=1, go to RESP.
  - RESP: pulse rspN_valid for the granted port, go to IDLE.
- Arbitration:
  - Round-robin over a last-grant pointer.
  - When both ports request, the port other than last-grant wins.
  - When only one port requests, that port wins.
  - last_grant resets to 1, so port 0 wins the first tie.
- eng_cmd_op is constant, derived from QUAD_EN. eng_cmd_addr is the latched address; it is meaningful only in ISSUE.
- If init_done deasserts mid-transaction, the transaction completes normally; the IDLE check then routes to WAIT_INIT.
- eng_rsp_valid arriving outside WAIT_RSP is ignored. That includes a late response after a timeout.
- If eng_rsp_valid and the timeout condition occur in the same cycle, the response wins: data is latched with err=0.
- Reset values: state=WAIT_INIT, last_grant=1, counter=0, addr=0. rsp_data=0, rsp_err=0, and every valid, ready, abort and busy output is 0.
- Reset is honoured mid-operation: an asserted ARESETn drops every output to its reset value immediately, regardless of state.

## Timing
- Cycle A, IDLE: reqN_ready=1 and the address is latched at the edge.
- Cycle A+1: eng_cmd_valid=1.
- If eng_cmd_ready=1 in cycle A+1, WAIT_RSP starts at A+2.
- An engine response in cycle B puts rspN_valid=1 in cycle B+1, with rsp_data valid from B+1.
- Minimum accept-to-response latency is 3 cycles: response at A+2, rspN_valid at A+3.
- Back-to-back: the earliest next grant is the cycle after RESP. Throughput is one transaction per 4 or more cycles.
- Timeout: eng_abort pulses in the (TIMEOUT)th WAIT_RSP cycle and rspN_valid follows in the next cycle.
- Requesters must hold valid and address until ready. ready is never asserted without valid.

## Test plan
- Reset, then init_done held 0 for 20 cycles with req0_valid=1: req0_ready stays 0 and eng_cmd_valid stays 0. Raise init_done: req0_ready pulses exactly 1 cycle later.
- Single read: req0 addr=24'h000100, QUAD_EN=1, engine ready at once, engine returns 32'hDEADBEEF 5 cycles later. Required: eng_cmd_op=8'hEB, eng_cmd_addr=24'h000100, then rsp0_valid one cycle after eng_rsp_valid with rsp_data=32'hDEADBEEF and rsp_err=0.
- Contention: req0 and req1 held continuously for 4 transactions. Grants are 0,1,0,1 and rsp1_valid never fires for a port-0 transaction.
- Timeout with TIMEOUT=8 and the engine silent: eng_abort pulses once, then rspN_valid with rsp_data=32'hFFFFFFFF and rsp_err=1. A late eng_rsp_valid afterwards causes no response.
- Response and timeout in the same cycle: rsp_err=0 and the engine data is returned.
- ARESETn pulsed low during WAIT_RSP: all outputs drop to their reset values asynchronously and the state returns to WAIT_INIT.
